vga_timing_gen: RTL
===================

// Module: vga_timing_gen
// PURPOSE
//   Parametrised raster timing generator: horizontal + vertical pixel counters, sync pulses, active-video flag, line/frame strobes.
//   Replaces standalone per-axis counters; one instance drives the pixel pipeline and the VGA pins.
//   Any mode via parameters; configurable sync polarity; pixel-clock enable allows clk faster than pixel rate.
// PARAMETERS
//   H_VISIBLE  640  visible pixels per line
//   H_FRONT    16   horizontal front porch (pixels)
//   H_SYNC     96   hsync pulse width (pixels)
//   H_BACK     48   horizontal back porch (pixels)
//   V_VISIBLE  480  visible lines per frame
//   V_FRONT    10   vertical front porch (lines)
//   V_SYNC     2    vsync pulse width (lines)
//   V_BACK     33   vertical back porch (lines)
//   HSYNC_POL  0    hsync active level (0 = active-low)
//   VSYNC_POL  0    vsync active level
//   CNT_W      16   width of h_count / v_count
// PORTS
//   clk          in   1      system clock
//   rst_n        in   1      asynchronous reset, active-low
//   pix_en       in   1      pixel-clock enable; counters advance only when high
//   h_count      out  CNT_W  current pixel column, 0..H_TOTAL-1
//   v_count      out  CNT_W  current line, 0..V_TOTAL-1
//   hsync        out  1      horizontal sync, level per HSYNC_POL
//   vsync        out  1      vertical sync, level per VSYNC_POL
//   active       out  1      high when h_count<H_VISIBLE && v_count<V_VISIBLE
//   line_end     out  1      one-clk pulse on the pix_en cycle where h wraps
//   frame_end    out  1      one-clk pulse on the pix_en cycle where h and v both wrap
// BEHAVIOUR
//   - H_TOTAL=H_VISIBLE+H_FRONT+H_SYNC+H_BACK (800); V_TOTAL likewise (525).
//   - Reset (async assert, sync release): h_count=0, v_count=0, hsync=~HSYNC_POL, vsync=~VSYNC_POL, active=0, line_end=0, frame_end=0.
//   - pix_en=1: h_count<H_TOTAL-1 -> h_count+1; else h_count->0, line_end=1, v_count advances.
//   - v advance: v_count<V_TOTAL-1 -> +1; else v_count->0 and frame_end=1 (same cycle as line_end).
//   - pix_en=0: all counters hold; line_end/frame_end=0; hsync/vsync/active hold.
//   - hsync active when H_VISIBLE+H_FRONT <= h_count < H_VISIBLE+H_FRONT+H_SYNC (656..751).
//   - vsync active when V_VISIBLE+V_FRONT <= v_count < V_VISIBLE+V_FRONT+V_SYNC (490..491); changes with v_count, aligned to line start.
//   - hsync/vsync/active decoded combinationally from registered counters, gated to reset values while rst_n=0: zero latency vs h_count/v_count.
//   - Strobes registered: asserted the clk after the wrapping pix_en edge, i.e. coincident with h_count=0.
//   - Reset mid-frame: immediate return to (0,0); no partial strobe emitted.
//   - Elaboration: $error if H_TOTAL-1 or V_TOTAL-1 exceeds 2**CNT_W-1, or any porch/sync/visible parameter is 0.
// CONFIGURATION
//   VGA_TIMING_REG_OUT_EN defined: hsync, vsync, active registered; h_count/v_count/strobes delayed one clk to stay aligned;
//     total output latency +1 clk; reset values unchanged; pix_en=0 still holds all outputs.
//   Undefined: combinational decode as above, zero added latency.
// STRUCTURE
//   - Package vga_timing_pkg: default-mode localparams (640x480@60 porch/sync values), H_TOTAL/V_TOTAL helper functions, polarity enum.
//   - Sub-module vga_axis_counter (params VISIBLE/FRONT/SYNC/BACK/POL/CNT_W; ports clk, rst_n, inc, count, sync, visible, wrap),
//     instantiated twice: horizontal (inc=pix_en), vertical (inc=pix_en & h wrap).
// TESTING
//   1. Reset release, pix_en=1, defaults -> h_count 0..799 then 0; line_end with h_count=0; v_count 0->1.
//   2. Defaults -> hsync=1 at h=655, 0 for h=656..751, 1 at h=752; active=0 from h=640.
//   3. Run to v=524,h=799 -> next pix_en: (0,0), line_end=1 and frame_end=1 same clk; vsync=0 only for v=490..491.
//   4. pix_en toggled 1-of-2 clks -> counts advance every second clk; strobes exactly one clk wide; outputs hold when pix_en=0.
//   5. rst_n low at (h=300,v=200) -> outputs at reset values immediately; release -> restart from (0,0).
//   6. Params H 4/1/2/1, V 3/1/1/1, POLs=1, CNT_W=4, with and without VGA_TIMING_REG_OUT_EN -> hsync=1 at h=5..6; latency 0 vs 1 clk.

Source files
------------

// File: rtl/vga_timing_pkg.sv
// Shared definitions for the VGA raster timing generator: 640x480@60 defaults,
// axis-total helpers and the sync polarity type.
package vga_timing_pkg;

    typedef enum logic {
        SYNC_ACTIVE_LOW  = 1'b0,
        SYNC_ACTIVE_HIGH = 1'b1
    } sync_pol_e;

    localparam int DEF_H_VISIBLE = 640;
    localparam int DEF_H_FRONT   = 16;
    localparam int DEF_H_SYNC    = 96;
    localparam int DEF_H_BACK    = 48;
    localparam int DEF_V_VISIBLE = 480;
    localparam int DEF_V_FRONT   = 10;
    localparam int DEF_V_SYNC    = 2;
    localparam int DEF_V_BACK    = 33;
    localparam int DEF_CNT_W     = 16;

    localparam sync_pol_e DEF_SYNC_POL = SYNC_ACTIVE_LOW;

    function automatic int axis_total(input int visible, input int front,
                                      input int sync, input int back);
        return visible + front + sync + back;
    endfunction

    function automatic int h_total(input int visible, input int front,
                                   input int sync, input int back);
        return axis_total(visible, front, sync, back);
    endfunction

    function automatic int v_total(input int visible, input int front,
                                   input int sync, input int back);
        return axis_total(visible, front, sync, back);
    endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync/visible decode and a
// registered wrap strobe that coincides with count returning to zero.
module vga_axis_counter
    import vga_timing_pkg::*;
#(
    parameter int        VISIBLE = DEF_H_VISIBLE,
    parameter int        FRONT   = DEF_H_FRONT,
    parameter int        SYNC    = DEF_H_SYNC,
    parameter int        BACK    = DEF_H_BACK,
    parameter sync_pol_e POL     = DEF_SYNC_POL,
    parameter int        CNT_W   = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             inc,
    output logic [CNT_W-1:0] count,
    output logic             sync,
    output logic             visible,
    output logic             wrap
);

    localparam int               TOTAL      = axis_total(VISIBLE, FRONT, SYNC, BACK);
    localparam logic [CNT_W-1:0] LAST       = CNT_W'(TOTAL - 1);
    localparam logic [CNT_W-1:0] VIS_END    = CNT_W'(VISIBLE);
    localparam logic [CNT_W-1:0] SYNC_START = CNT_W'(VISIBLE + FRONT);
    localparam logic [CNT_W-1:0] SYNC_END   = CNT_W'(VISIBLE + FRONT + SYNC);
    localparam logic             SYNC_ACT   = logic'(POL);

    logic at_last;
    logic in_sync;

    assign at_last = (count == LAST);
    assign in_sync = (count >= SYNC_START) && (count < SYNC_END);

    // Decodes are forced to their idle levels while reset is held, so the
    // outputs read as the reset state even though count 0 is a visible pixel.
    assign sync    = (rst_n && in_sync) ? SYNC_ACT : ~SYNC_ACT;
    assign visible = rst_n && (count < VIS_END);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            wrap  <= 1'b0;
        end else begin
            // NOTE: non-blocking assignments keep every flop sampling the
            // pre-edge value of count, so wrap and the new count agree.
            wrap <= inc && at_last;
            if (inc) begin
                count <= at_last ? '0 : count + 1'b1;
            end
        end
    end

endmodule

// File: rtl/vga_timing_gen.sv
// Parametrised VGA raster timing generator. Define VGA_TIMING_REG_OUT_EN to
// register hsync/vsync/active (all outputs then lag the counters by one clk).
module vga_timing_gen
    import vga_timing_pkg::*;
#(
    parameter int H_VISIBLE = DEF_H_VISIBLE,
    parameter int H_FRONT   = DEF_H_FRONT,
    parameter int H_SYNC    = DEF_H_SYNC,
    parameter int H_BACK    = DEF_H_BACK,
    parameter int V_VISIBLE = DEF_V_VISIBLE,
    parameter int V_FRONT   = DEF_V_FRONT,
    parameter int V_SYNC    = DEF_V_SYNC,
    parameter int V_BACK    = DEF_V_BACK,
    parameter bit HSYNC_POL = 1'b0,
    parameter bit VSYNC_POL = 1'b0,
    parameter int CNT_W     = DEF_CNT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             pix_en,
    output logic [CNT_W-1:0] h_count,
    output logic [CNT_W-1:0] v_count,
    output logic             hsync,
    output logic             vsync,
    output logic             active,
    output logic             line_end,
    output logic             frame_end
);

    localparam int H_TOTAL = h_total(H_VISIBLE, H_FRONT, H_SYNC, H_BACK);
    localparam int V_TOTAL = v_total(V_VISIBLE, V_FRONT, V_SYNC, V_BACK);

    if (H_TOTAL - 1 > 2**CNT_W - 1) begin : g_h_range_err
        $error("vga_timing_gen: H_TOTAL-1 does not fit in CNT_W bits");
    end
    if (V_TOTAL - 1 > 2**CNT_W - 1) begin : g_v_range_err
        $error("vga_timing_gen: V_TOTAL-1 does not fit in CNT_W bits");
    end
    if (H_VISIBLE == 0 || H_FRONT == 0 || H_SYNC == 0 || H_BACK == 0 ||
        V_VISIBLE == 0 || V_FRONT == 0 || V_SYNC == 0 || V_BACK == 0) begin : g_zero_err
        $error("vga_timing_gen: visible/porch/sync parameters must be non-zero");
    end

    logic [CNT_W-1:0] h_cnt;
    logic [CNT_W-1:0] v_cnt;
    logic             h_sync_c;
    logic             v_sync_c;
    logic             h_vis;
    logic             v_vis;
    logic             h_wrap;
    logic             v_wrap;
    logic             h_last;

    // The vertical axis steps on the same pix_en edge that wraps the line.
    assign h_last = (h_cnt == CNT_W'(H_TOTAL - 1));

    vga_axis_counter #(
        .VISIBLE (H_VISIBLE),
        .FRONT   (H_FRONT),
        .SYNC    (H_SYNC),
        .BACK    (H_BACK),
        .POL     (sync_pol_e'(HSYNC_POL)),
        .CNT_W   (CNT_W)
    ) u_h_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pix_en),
        .count   (h_cnt),
        .sync    (h_sync_c),
        .visible (h_vis),
        .wrap    (h_wrap)
    );

    vga_axis_counter #(
        .VISIBLE (V_VISIBLE),
        .FRONT   (V_FRONT),
        .SYNC    (V_SYNC),
        .BACK    (V_BACK),
        .POL     (sync_pol_e'(VSYNC_POL)),
        .CNT_W   (CNT_W)
    ) u_v_axis (
        .clk     (clk),
        .rst_n   (rst_n),
        .inc     (pix_en & h_last),
        .count   (v_cnt),
        .sync    (v_sync_c),
        .visible (v_vis),
        .wrap    (v_wrap)
    );

`ifdef VGA_TIMING_REG_OUT_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            h_count   <= '0;
            v_count   <= '0;
            hsync     <= ~HSYNC_POL;
            vsync     <= ~VSYNC_POL;
            active    <= 1'b0;
            line_end  <= 1'b0;
            frame_end <= 1'b0;
        end else begin
            h_count   <= h_cnt;
            v_count   <= v_cnt;
            hsync     <= h_sync_c;
            vsync     <= v_sync_c;
            active    <= h_vis & v_vis;
            line_end  <= h_wrap;
            frame_end <= v_wrap;
        end
    end
`else
    assign h_count   = h_cnt;
    assign v_count   = v_cnt;
    assign hsync     = h_sync_c;
    assign vsync     = v_sync_c;
    assign active    = h_vis & v_vis;
    assign line_end  = h_wrap;
    assign frame_end = v_wrap;
`endif

endmodule
